// File: rtl/irq_controller.sv
// Vectored interrupt controller: edge/level capture, fixed priority with
// nesting, and a three-instruction injection sequence toward the CPU.
module irq_controller #(
  parameter int          N_IRQ      = 8,
  parameter logic [15:0] VEC_BASE   = 16'hFFF8,
  parameter logic [28:0] INSTR_PUSH = 29'b10110000000001111000000000001,
  parameter logic [28:0] INSTR_SAVE = 29'b00101111111110000000000000001,
  parameter logic [28:0] INSTR_JMP  = 29'b10010000000000000000000000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] mask,
  input  logic [N_IRQ-1:0] edge_mode,
  input  logic             step,
  input  logic             eoi,
  output logic [28:0]      instr,
  output logic             interrupt,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [3:0]       active_id
);

  typedef enum logic [1:0] {
    IDLE,
    S_PUSH,
    S_SAVE,
    S_JMP
  } state_t;

  state_t state_q, state_d;

  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] isv_q;
  logic [3:0]       id_q;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] cand_oh;
  logic [N_IRQ-1:0] upto;
  logic [N_IRQ-1:0] isv_lo;
  logic [N_IRQ-1:0] isv_eff;
  logic [N_IRQ-1:0] clr;
  logic [3:0]       cand_id;
  logic             cand_vld;
  logic             accept;
  logic [15:0]      vec;

  assign rise    = irq & ~prev_q & edge_mode;
  assign pending = RST ? '0 : ((pend_q & edge_mode) | (irq & ~edge_mode));
  assign req     = pending & mask;

  // Lowest set bit wins on both the request and the in-service side.
  assign cand_oh = req & (~req + N_IRQ'(1));
  assign upto    = cand_oh | (cand_oh - N_IRQ'(1));
  assign isv_lo  = isv_q & (~isv_q + N_IRQ'(1));
  assign isv_eff = eoi ? (isv_q & ~isv_lo) : isv_q;

  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        cand_vld = 1'b1;
        cand_id  = 4'(i);
      end
    end
  end

  // Preempt only channels strictly more urgent than anything in service.
  assign accept = (state_q == IDLE) && cand_vld
               && ((isv_eff & upto) == '0);
  assign clr    = accept ? cand_oh : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = S_PUSH;
      S_PUSH:  if (step) state_d = S_SAVE;
      S_SAVE:  if (step) state_d = S_JMP;
      S_JMP:   if (step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      isv_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= irq;
      pend_q  <= (pend_q & ~clr) | rise;
      isv_q   <= isv_eff | clr;
      if (accept) id_q <= cand_id;
    end
  end

  assign vec = VEC_BASE + {12'd0, id_q};

  always_comb begin
    instr = '0;
    unique case (state_q)
      IDLE:    instr = '0;
      S_PUSH:  instr = INSTR_PUSH;
      S_SAVE:  instr = INSTR_SAVE;
      S_JMP:   instr = INSTR_JMP | {13'd0, vec};
      default: instr = '0;
    endcase
  end

  assign interrupt  = (state_q != IDLE);
  assign in_service = isv_q;
  assign active_id  = id_q;

endmodule
